// File: rtl/regfile_dump_pkg.sv
// ----------------------------------------------------------------------------
// regfile_dump_pkg
// Shared definitions for the register-file dump sequencer: default widths,
// register count and the 3-bit FSM state encoding.
// The CHECK state only becomes reachable when REGFILE_DUMP_CHECKSUM_EN is
// defined at build time.
// ----------------------------------------------------------------------------
package regfile_dump_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NUM_REGS       = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        SEND  = 3'd2,
        DONE  = 3'd3,
        CHECK = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// ----------------------------------------------------------------------------
// regfile_dump_if
// Valid/ready word stream produced by regfile_dump.
//   out_valid  word valid              (master -> slave)
//   out_ready  downstream accepts word (slave  -> master)
//   out_data   stream word             (master -> slave)
//   out_index  register index of word  (master -> slave)
//   out_last   final word of the dump  (master -> slave)
// ----------------------------------------------------------------------------
interface regfile_dump_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index,
        input  out_last
    );

endinterface

// File: rtl/regfile_dump.sv
// ----------------------------------------------------------------------------
// regfile_dump
// Read-side sequencer for the CPU register file. A start pulse in IDLE walks
// registers FIRST_REG..LAST_REG on one combinational read port and streams
// each captured word over a valid/ready interface.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-high reset
//   start         begin a dump (sampled only in IDLE)
//   busy          high while a dump is in progress
//   done          one-cycle pulse when the dump completes
//   read_address  address to the regfile read port
//   read_data     combinational regfile read data
//   out           stream master (out_valid/ready/data/index/last)
//
// Build option REGFILE_DUMP_CHECKSUM_EN: append an XOR checksum word (index 0,
// out_last=1) after the data words; data words then never assert out_last.
// ----------------------------------------------------------------------------
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] read_data,
    regfile_dump_if.master        out
);

    localparam logic [ADDR_WIDTH-1:0] FirstAddr = ADDR_WIDTH'(FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(LAST_REG);

    // An inverted range would never terminate cleanly, so refuse to elaborate.
    if (FIRST_REG > LAST_REG) begin : g_bad_range
        $error("regfile_dump: FIRST_REG must not exceed LAST_REG");
    end

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic                  last_q,  last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] acc_q,   acc_d;
`endif

    // State and datapath registers; reset may land mid-dump and returns
    // everything to the idle, all-zero output condition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= FirstAddr;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            index_q <= index_d;
            last_q  <= last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // Next-state logic. The address is compared against LAST_REG before it
    // is incremented, so the counter never wraps even when LAST_REG is the
    // top of the address space.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        index_d = index_q;
        last_d  = last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    addr_d  = FirstAddr;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            READ: begin
                data_d  = read_data;
                index_d = addr_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                last_d  = 1'b0;
                acc_d   = acc_q ^ read_data;
`else
                last_d  = (addr_q == LastAddr);
`endif
                state_d = SEND;
            end
            SEND: begin
                if (out.out_ready) begin
                    last_d = 1'b0;
                    if (addr_q == LastAddr) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        data_d  = acc_q;
                        index_d = '0;
                        last_d  = 1'b1;
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = READ;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            CHECK: begin
                if (out.out_ready) begin
                    last_d  = 1'b0;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                last_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from state or taken straight from registers.
    always_comb begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out.out_valid = (state_q == SEND) || (state_q == CHECK);
`else
        out.out_valid = (state_q == SEND);
`endif
        out.out_data  = data_q;
        out.out_index = index_q;
        out.out_last  = last_q;
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        read_address  = addr_q;
    end

endmodule

// File: tb/tb_regfile_dump.sv
// ----------------------------------------------------------------------------
// tb_regfile_dump
// Self-checking bench for regfile_dump. Three instances share one register
// array: a full dump (0..31), a single register (5..5) and a sub-range
// (1..4). Expected streams come from a queue model built from the register
// contents and the dump range.
// ----------------------------------------------------------------------------
module tb_regfile_dump;

    import regfile_dump_pkg::*;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int Feat = 1;
`else
    localparam int Feat = 0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [4:0]  index;
        logic        last;
    } word_t;

    typedef struct {
        int          dut;
        int          mode;
        int          stallIdx;
        int          stallCycles;
        bit          midStart;
        int          expWords;
        logic [31:0] expFinal;
    } vector_t;

    logic        clock;
    logic        reset;
    logic        startArr[3];
    logic        readyArr[3];
    logic        mBusy[3];
    logic        mDone[3];
    logic        mValid[3];
    logic        mLast[3];
    logic [31:0] mData[3];
    logic [4:0]  mIndex[3];
    logic [4:0]  rdAddr[3];
    logic [31:0] rdData[3];
    logic [31:0] tbRegs[32];

    int numCompared;
    int numMismatched;

    regfile_dump_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifFull();
    regfile_dump_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifOne();
    regfile_dump_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifSub();

    regfile_dump #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIRST_REG(0), .LAST_REG(31)) dutFull (
        .clock(clock), .reset(reset), .start(startArr[0]), .busy(mBusy[0]), .done(mDone[0]),
        .read_address(rdAddr[0]), .read_data(rdData[0]), .out(ifFull.master));
    regfile_dump #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIRST_REG(5), .LAST_REG(5)) dutOne (
        .clock(clock), .reset(reset), .start(startArr[1]), .busy(mBusy[1]), .done(mDone[1]),
        .read_address(rdAddr[1]), .read_data(rdData[1]), .out(ifOne.master));
    regfile_dump #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIRST_REG(1), .LAST_REG(4)) dutSub (
        .clock(clock), .reset(reset), .start(startArr[2]), .busy(mBusy[2]), .done(mDone[2]),
        .read_address(rdAddr[2]), .read_data(rdData[2]), .out(ifSub.master));

    // Register file read ports are combinational, as on the CPU.
    assign rdData[0] = tbRegs[rdAddr[0]];
    assign rdData[1] = tbRegs[rdAddr[1]];
    assign rdData[2] = tbRegs[rdAddr[2]];

    assign ifFull.out_ready = readyArr[0];
    assign ifOne.out_ready  = readyArr[1];
    assign ifSub.out_ready  = readyArr[2];

    assign mValid[0] = ifFull.out_valid;
    assign mValid[1] = ifOne.out_valid;
    assign mValid[2] = ifSub.out_valid;
    assign mLast[0]  = ifFull.out_last;
    assign mLast[1]  = ifOne.out_last;
    assign mLast[2]  = ifSub.out_last;
    assign mData[0]  = ifFull.out_data;
    assign mData[1]  = ifOne.out_data;
    assign mData[2]  = ifSub.out_data;
    assign mIndex[0] = ifFull.out_index;
    assign mIndex[1] = ifOne.out_index;
    assign mIndex[2] = ifSub.out_index;

    // 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int firstOf(input int d);
        case (d)
            1:       return 5;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int lastOf(input int d);
        case (d)
            1:       return 5;
            2:       return 4;
            default: return 31;
        endcase
    endfunction

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Write port of the register file, used between dumps.
    task automatic writeReg(input int addr, input logic [31:0] value);
        @(negedge clock);
        tbRegs[addr] = value;
    endtask

    // Run one dump on instance d and score every handshaked word.
    // mode 0: ready high, 1: random ready, 2: stall stallCycles on stallIdx.
    task automatic applyStimulus(input int d, input int mode, input int stallIdx, input int stallCycles,
                                 input bit midStart, input int expWords, input bit checkFinal,
                                 input logic [31:0] expFinal);
        word_t       expQ[$];
        word_t       w;
        logic [31:0] chk;
        logic [31:0] finalData;
        int          first;
        int          last;
        int          gotWords;
        int          doneCount;
        int          doneCyc;
        int          stalled;
        int          lastSeen;
        bit          finished;
        logic        rdy;

        first = firstOf(d);
        last  = lastOf(d);
        chk   = '0;
        for (int i = first; i <= last; i++) begin
            w.data  = tbRegs[i];
            w.index = 5'(i);
            w.last  = (Feat == 0) && (i == last);
            expQ.push_back(w);
            chk ^= tbRegs[i];
        end
        if (Feat != 0) begin
            w.data  = chk;
            w.index = 5'd0;
            w.last  = 1'b1;
            expQ.push_back(w);
        end

        gotWords  = 0;
        doneCount = 0;
        doneCyc   = -1;
        stalled   = 0;
        lastSeen  = 0;
        finished  = 0;
        finalData = '0;

        @(negedge clock);
        startArr[d] = 1'b1;
        @(negedge clock);
        startArr[d] = 1'b0;

        for (int c = 0; c < 600 && !finished; c++) begin
            if (mode == 0 && c == 0) begin
                checkOutput("busyAfterStart", 32'(mBusy[d]), 32'd1);
                checkOutput("validAfterStart", 32'(mValid[d]), 32'd0);
            end
            if (mode == 0 && c == 1) begin
                checkOutput("firstValid", 32'(mValid[d]), 32'd1);
                checkOutput("firstIndex", 32'(mIndex[d]), 32'(first));
            end
            if (midStart) startArr[d] = (c == 10);
            if (mDone[d]) begin
                doneCount++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (doneCyc >= 0 && c == doneCyc + 1) begin
                checkOutput("busyAfterDone", 32'(mBusy[d]), 32'd0);
                checkOutput("donePulseWidth", 32'(mDone[d]), 32'd0);
                finished = 1;
            end

            rdy = 1'b1;
            if (mode == 1) rdy = 1'($urandom_range(0, 1));
            if (mode == 2 && mValid[d] && mIndex[d] == 5'(stallIdx) && stalled < stallCycles
                && expQ.size() > 0) begin
                rdy = 1'b0;
                stalled++;
                checkOutput("stallData", mData[d], expQ[0].data);
                checkOutput("stallIndex", 32'(mIndex[d]), 32'(expQ[0].index));
            end
            readyArr[d] = rdy;

            if (mValid[d] && rdy) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraWord", 32'd1, 32'd0);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("wordData", mData[d], w.data);
                    checkOutput("wordIndex", 32'(mIndex[d]), 32'(w.index));
                    checkOutput("wordLast", 32'(mLast[d]), 32'(w.last));
                    gotWords++;
                    if (mLast[d]) begin
                        lastSeen++;
                        finalData = mData[d];
                    end
                end
            end
            @(negedge clock);
        end

        startArr[d] = 1'b0;
        readyArr[d] = 1'b1;
        checkOutput("dumpFinished", 32'(finished), 32'd1);
        checkOutput("wordCount", 32'(gotWords), 32'(expWords));
        checkOutput("doneCount", 32'(doneCount), 32'd1);
        checkOutput("lastCount", 32'(lastSeen), 32'd1);
        if (mode == 2) checkOutput("stallCycles", 32'(stalled), 32'(stallCycles));
        if (checkFinal) checkOutput("finalWord", finalData, expFinal);
        if (mode == 0) checkOutput("doneLatency", 32'(doneCyc), 32'(2 * (last - first + 1) + Feat));
    endtask

    // Outputs of all instances must be at their reset values.
    task automatic checkResetState(input string tag);
        for (int d = 0; d < 3; d++) begin
            checkOutput({tag, "Valid"}, 32'(mValid[d]), 32'd0);
            checkOutput({tag, "Last"}, 32'(mLast[d]), 32'd0);
            checkOutput({tag, "Busy"}, 32'(mBusy[d]), 32'd0);
            checkOutput({tag, "Done"}, 32'(mDone[d]), 32'd0);
            checkOutput({tag, "Data"}, mData[d], 32'd0);
            checkOutput({tag, "Index"}, 32'(mIndex[d]), 32'd0);
            checkOutput({tag, "Addr"}, 32'(rdAddr[d]), 32'(firstOf(d)));
        end
    endtask

    vector_t vecs[5];

    initial begin
        bit found;

        numCompared   = 0;
        numMismatched = 0;
        reset         = 1'b1;
        for (int d = 0; d < 3; d++) begin
            startArr[d] = 1'b0;
            readyArr[d] = 1'b1;
        end
        for (int i = 0; i < 32; i++) tbRegs[i] = '0;

        // Dump scenarios with their expected word counts and final words.
        vecs[0] = '{dut: 0, mode: 0, stallIdx: 0, stallCycles: 0, midStart: 0,
                    expWords: 32 + Feat, expFinal: (Feat != 0) ? 32'h0 : 32'd131};
        vecs[1] = '{dut: 0, mode: 2, stallIdx: 3, stallCycles: 5, midStart: 0,
                    expWords: 32 + Feat, expFinal: (Feat != 0) ? 32'h0 : 32'd131};
        vecs[2] = '{dut: 0, mode: 0, stallIdx: 0, stallCycles: 0, midStart: 1,
                    expWords: 32 + Feat, expFinal: (Feat != 0) ? 32'h0 : 32'd131};
        vecs[3] = '{dut: 1, mode: 0, stallIdx: 0, stallCycles: 0, midStart: 0,
                    expWords: 1 + Feat, expFinal: 32'd105};
        vecs[4] = '{dut: 2, mode: 0, stallIdx: 0, stallCycles: 0, midStart: 0,
                    expWords: 4 + Feat, expFinal: (Feat != 0) ? 32'h0000000C : 32'd104};

        repeat (3) @(negedge clock);
        checkResetState("reset");
        reset = 1'b0;

        for (int i = 0; i < 32; i++) writeReg(i, 32'(i + 100));

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].dut, vecs[v].mode, vecs[v].stallIdx, vecs[v].stallCycles,
                          vecs[v].midStart, vecs[v].expWords, 1'b1, vecs[v].expFinal);
        end

        // Asynchronous reset between edges while word 10 is on the bus.
        @(negedge clock);
        startArr[0] = 1'b1;
        @(negedge clock);
        startArr[0] = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (mValid[0] && mIndex[0] == 5'd10) found = 1;
            else @(negedge clock);
        end
        checkOutput("reachedWord10", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkResetState("midReset");
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 1'b0, 32 + Feat, 1'b1, (Feat != 0) ? 32'h0 : 32'd131);

        // Random register contents with random backpressure.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) writeReg(i, $urandom);
            applyStimulus(0, 1, 0, 0, 1'b0, 32 + Feat, 1'b0, 32'h0);
            applyStimulus(2, 1, 0, 0, 1'b0, 4 + Feat, 1'b0, 32'h0);
            applyStimulus(1, 1, 0, 0, 1'b0, 1 + Feat, 1'b1, tbRegs[5]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
